spi_burst_ram_slave: RTL

Parametrised SPI-slave memory: a single-block successor to the fixed 256x8 SPI-plus-RAM pairing. It decodes MOSI frames into address, write and read operations on an internal 2^ADDR_WIDTH x DATA_WIDTH memory. Unlike the previous generation, it supports burst transfers with address auto-increment for both writes and reads. It sits directly behind the chip's SPI pads, with everything on the system clock.

---
 rtl/spi_burst_ram_slave_if.sv | 28 ++
 rtl/spi_burst_ram_slave.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/spi_burst_ram_slave_if.sv
// ----------------------------------------------------------------------------
// spi_burst_ram_slave_if
// Serial pad-side bundle of the SPI burst RAM slave.
//   SS_n : slave select, active low (master -> slave)
//   MOSI : serial data into the slave, MSB first (master -> slave)
//   MISO : serial data out of the slave, MSB first (slave -> master)
//   busy : frame-in-progress flag (slave -> master)
// ----------------------------------------------------------------------------
interface spi_burst_ram_slave_if;
    logic SS_n;
    logic MOSI;
    logic MISO;
    logic busy;

    modport slave (
        input  SS_n,
        input  MOSI,
        output MISO,
        output busy
    );

    modport master (
        output SS_n,
        output MOSI,
        input  MISO,
        input  busy
    );
endinterface

// File: rtl/spi_burst_ram_slave.sv
// ----------------------------------------------------------------------------
// spi_burst_ram_slave
// SPI-slave front end to a 2^ADDR_WIDTH x DATA_WIDTH memory, all on clk.
// Frame: 2 opcode bits (00 write, 01 read, 1x ignored), ADDR_WIDTH address
// bits, then burst data with address auto-increment (wrapping).
// Ports:
//   clk  : system clock, everything sampled on the rising edge
//   rst  : asynchronous active-high reset
//   bus  : slave modport carrying SS_n, MOSI (in) and MISO, busy (out);
//          MISO and busy come straight from flops
// ----------------------------------------------------------------------------
module spi_burst_ram_slave #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    spi_burst_ram_slave_if.slave  bus
);
    localparam int CNT_MAX = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CW      = $clog2(CNT_MAX) + 1;
    localparam logic [CW-1:0]         A_LAST   = CW'(ADDR_WIDTH - 1);
    localparam logic [CW-1:0]         D_LAST   = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]         CNT_ZERO = CW'(0);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ZERO = ADDR_WIDTH'(0);
    localparam logic [DATA_WIDTH-1:0] DAT_ZERO = DATA_WIDTH'(0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_OPC    = 3'd1,
        S_ADDR   = 3'd2,
        S_WDATA  = 3'd3,
        S_RDUMMY = 3'd4,
        S_RDATA  = 3'd5,
        S_IGNORE = 3'd6
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]           bcnt_q, bcnt_d;
    logic [DATA_WIDTH-1:0]   wsr_q, wsr_d;
    logic [DATA_WIDTH-1:0]   rsr_q, rsr_d;
    logic                    op_hi_q, op_hi_d;
    logic                    is_read_q, is_read_d;
    logic                    miso_q, miso_d;
    logic                    busy_q, busy_d;
    logic                    we_s;

    // Storage deliberately has no reset so contents survive rst and frames.
    logic [DATA_WIDTH-1:0]   mem_q [0:(1 << ADDR_WIDTH) - 1];

    assign bus.MISO = miso_q;
    assign bus.busy = busy_q;

    // State, pointer, counters, shift registers and output flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ptr_q     <= PTR_ZERO;
            bcnt_q    <= CNT_ZERO;
            wsr_q     <= DAT_ZERO;
            rsr_q     <= DAT_ZERO;
            op_hi_q   <= 1'b0;
            is_read_q <= 1'b0;
            miso_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            bcnt_q    <= bcnt_d;
            wsr_q     <= wsr_d;
            rsr_q     <= rsr_d;
            op_hi_q   <= op_hi_d;
            is_read_q <= is_read_d;
            miso_q    <= miso_d;
            busy_q    <= busy_d;
        end
    end

    // Memory write port; state is held in IDLE during rst so we_s stays low.
    always_ff @(posedge clk) begin
        if (we_s) begin
            mem_q[ptr_q] <= wsr_d;
        end else begin
            mem_q[ptr_q] <= mem_q[ptr_q];
        end
    end

    // Frame decoder: next state, datapath updates and next output values.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        bcnt_d    = bcnt_q;
        wsr_d     = wsr_q;
        rsr_d     = rsr_q;
        op_hi_d   = op_hi_q;
        is_read_d = is_read_q;
        we_s      = 1'b0;

        if ((state_q != S_IDLE) && bus.SS_n) begin
            // Deselect mid-frame: drop partial words and the pointer.
            state_d = S_IDLE;
            ptr_d   = PTR_ZERO;
            bcnt_d  = CNT_ZERO;
            wsr_d   = DAT_ZERO;
            rsr_d   = DAT_ZERO;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!bus.SS_n) begin
                        op_hi_d = bus.MOSI;
                        state_d = S_OPC;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_OPC: begin
                    if (op_hi_q) begin
                        state_d = S_IGNORE;
                    end else begin
                        is_read_d = bus.MOSI;
                        bcnt_d    = CNT_ZERO;
                        state_d   = S_ADDR;
                    end
                end
                S_ADDR: begin
                    ptr_d    = ptr_q << 1;
                    ptr_d[0] = bus.MOSI;
                    if (bcnt_q == A_LAST) begin
                        bcnt_d  = CNT_ZERO;
                        state_d = is_read_q ? S_RDUMMY : S_WDATA;
                    end else begin
                        bcnt_d  = bcnt_q + CNT_ONE;
                    end
                end
                S_WDATA: begin
                    wsr_d    = wsr_q << 1;
                    wsr_d[0] = bus.MOSI;
                    if (bcnt_q == D_LAST) begin
                        we_s   = 1'b1;
                        ptr_d  = ptr_q + PTR_ONE;
                        bcnt_d = CNT_ZERO;
                    end else begin
                        bcnt_d = bcnt_q + CNT_ONE;
                    end
                end
                S_RDUMMY: begin
                    rsr_d   = mem_q[ptr_q];
                    ptr_d   = ptr_q + PTR_ONE;
                    bcnt_d  = CNT_ZERO;
                    state_d = S_RDATA;
                end
                S_RDATA: begin
                    // bcnt counts bits already presented; reload right after bit 0.
                    if (bcnt_q == D_LAST) begin
                        rsr_d  = mem_q[ptr_q];
                        ptr_d  = ptr_q + PTR_ONE;
                        bcnt_d = CNT_ZERO;
                    end else begin
                        rsr_d  = rsr_q << 1;
                        bcnt_d = bcnt_q + CNT_ONE;
                    end
                end
                S_IGNORE: begin
                    state_d = S_IGNORE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // Outputs are computed from next state so they are flop outputs.
        miso_d = (state_d == S_RDATA) ? rsr_d[DATA_WIDTH-1] : 1'b0;
        busy_d = (state_d != S_IDLE);
    end
endmodule
